seq_hit_monitor: RTL and testbench

SEQ_HIT_MONITOR -- requirements
Module: seq_hit_monitor

---
 rtl/seq_hit_monitor.sv | 148 ++++++++++++++
 tb/tb_seq_hit_monitor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_hit_monitor.sv
// ============================================================================
// Module   : seq_hit_monitor
// Purpose  : Counts 101-detector hits per fixed window, presents each window
//            count as a valid/ready report with a threshold alarm and a
//            sticky overrun flag. Optional macro SEQ_HIT_MONITOR_TOTAL_EN
//            adds a saturating 16-bit lifetime hit counter (total_hits).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_hit_monitor #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8,
    parameter int THRESH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             y_in,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_count,
    output logic             rpt_alarm,
    output logic             overrun
`ifdef SEQ_HIT_MONITOR_TOTAL_EN
    ,
    output logic [15:0]      total_hits
`endif
);

    localparam int                WIN_W      = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0]  C_WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [31:0]       C_THRESH   = 32'(THRESH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIN_W-1:0]  r_win;
    logic [CNT_W-1:0]  r_hit;
    logic              r_valid;
    logic [CNT_W-1:0]  r_count;
    logic              r_alarm;
    logic              r_overrun;

    logic              w_active;
    logic              w_last;
    logic              w_load;
    logic              w_hshake;
    logic [CNT_W-1:0]  w_snap;
    logic [31:0]       w_snap_ext;
    logic              w_snap_alarm;

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (en)  w_state_nxt = ST_COUNT;
            ST_COUNT: if (!en) w_state_nxt = ST_IDLE;
            default:           w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Window datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_active     = (r_state == ST_COUNT);
        w_last       = w_active && (r_win == C_WIN_LAST);
        // Last-cycle hit is folded in so the report covers the whole window.
        w_snap       = (y_in && !(&r_hit)) ? (r_hit + CNT_W'(1)) : r_hit;
        w_snap_ext   = 32'(w_snap);
        w_snap_alarm = (w_snap_ext >= C_THRESH);
        w_load       = w_last;
        w_hshake     = r_valid && rpt_ready;
    end

    // Idle keeps both counters at zero, so entering COUNT starts at cycle 0
    // and any partial window is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win <= '0;
            r_hit <= '0;
        end else if (!w_active || w_last) begin
            r_win <= '0;
            r_hit <= '0;
        end else begin
            r_win <= r_win + WIN_W'(1);
            r_hit <= w_snap;
        end
    end

    // ------------------------------------------------------------------
    // Report register and handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_count   <= '0;
            r_alarm   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_count <= w_snap;
            r_alarm <= w_snap_alarm;
            if (r_valid && !rpt_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (w_hshake) begin
            r_valid <= 1'b0;
        end
    end

    assign rpt_valid = r_valid;
    assign rpt_count = r_count;
    assign rpt_alarm = r_alarm;
    assign overrun   = r_overrun;

`ifdef SEQ_HIT_MONITOR_TOTAL_EN
    logic [15:0] r_total;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_total <= '0;
        end else if (w_active && y_in && (r_total != 16'hFFFF)) begin
            r_total <= r_total + 16'd1;
        end
    end

    assign total_hits = r_total;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_hit_monitor.sv
// ============================================================================
// Module   : tb_seq_hit_monitor
// Purpose  : Directed self-checking bench for seq_hit_monitor
//            (WINDOW=8, CNT_W=3, THRESH=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_hit_monitor;

    localparam int WINDOW = 8;
    localparam int CNT_W  = 3;
    localparam int THRESH = 2;

    logic             clk;
    logic             rst;
    logic             en;
    logic             y_in;
    logic             rpt_valid;
    logic             rpt_ready;
    logic [CNT_W-1:0] rpt_count;
    logic             rpt_alarm;
    logic             overrun;
`ifdef SEQ_HIT_MONITOR_TOTAL_EN
    logic [15:0]      total_hits;
`endif

    int n_total = 0;
    int n_bad   = 0;

    seq_hit_monitor #(
        .WINDOW (WINDOW),
        .CNT_W  (CNT_W),
        .THRESH (THRESH)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .y_in       (y_in),
        .rpt_valid  (rpt_valid),
        .rpt_ready  (rpt_ready),
        .rpt_count  (rpt_count),
        .rpt_alarm  (rpt_alarm),
        .overrun    (overrun)
`ifdef SEQ_HIT_MONITOR_TOTAL_EN
        ,
        .total_hits (total_hits)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        y_in      = 1'b0;
        rpt_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // One IDLE->COUNT edge; the following cycle is window cycle 0.
    task automatic start();
        en   = 1'b1;
        y_in = 1'b0;
        tick();
    endtask

    task automatic run_window(input logic [7:0] pat, input logic [7:0] rdy);
        for (int i = 0; i < WINDOW; i++) begin
            y_in      = pat[i];
            rpt_ready = rdy[i];
            tick();
        end
        y_in      = 1'b0;
        rpt_ready = 1'b0;
    endtask

    task automatic chk_total(input string tag, input int exp);
`ifdef SEQ_HIT_MONITOR_TOTAL_EN
        chk(tag, 32'(total_hits), 32'(exp));
`endif
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; y_in = 1'b0; rpt_ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_valid", 32'(rpt_valid), 0);
        chk("rst_count", 32'(rpt_count), 0);
        chk("rst_alarm", 32'(rpt_alarm), 0);
        chk("rst_ovr",   32'(overrun),   0);
        chk_total("rst_total", 0);

        // Hits on cycles 2 and 4
        start();
        run_window(8'b0001_0100, 8'h00);
        chk("w24_valid", 32'(rpt_valid), 1);
        chk("w24_count", 32'(rpt_count), 2);
        chk("w24_alarm", 32'(rpt_alarm), 1);
        chk("w24_ovr",   32'(overrun),   0);
        chk_total("w24_total", 2);
        // Handshake without load: valid drops, payload holds
        rpt_ready = 1'b1;
        tick();
        rpt_ready = 1'b0;
        chk("hs_valid", 32'(rpt_valid), 0);
        chk("hs_count", 32'(rpt_count), 2);
        chk("hs_alarm", 32'(rpt_alarm), 1);

        // Every cycle hit: saturates at 7
        do_reset();
        start();
        run_window(8'hFF, 8'h00);
        chk("sat_valid", 32'(rpt_valid), 1);
        chk("sat_count", 32'(rpt_count), 7);
        chk("sat_alarm", 32'(rpt_alarm), 1);
        chk("sat_ovr",   32'(overrun),   0);
        chk_total("sat_total", 8);

        // Overwrite of an unconsumed report
        do_reset();
        start();
        run_window(8'b0000_0001, 8'h00);
        chk("ov1_count", 32'(rpt_count), 1);
        chk("ov1_alarm", 32'(rpt_alarm), 0);
        chk("ov1_ovr",   32'(overrun),   0);
        run_window(8'b0010_1010, 8'h00);
        chk("ov2_valid", 32'(rpt_valid), 1);
        chk("ov2_count", 32'(rpt_count), 3);
        chk("ov2_ovr",   32'(overrun),   1);
        chk_total("ov2_total", 4);

        // Reset mid-window with a pending report and overrun set
        y_in = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("mr_valid", 32'(rpt_valid), 0);
        chk("mr_count", 32'(rpt_count), 0);
        chk("mr_alarm", 32'(rpt_alarm), 0);
        chk("mr_ovr",   32'(overrun),   0);
        chk_total("mr_total", 0);
        // Back in IDLE: this hit is ignored and a fresh window follows
        rst = 1'b0;
        tick();
        y_in = 1'b0;
        run_window(8'b0000_0001, 8'h00);
        chk("mr_win_valid", 32'(rpt_valid), 1);
        chk("mr_win_count", 32'(rpt_count), 1);
        chk_total("mr_win_total", 1);

        // Ready exactly on the second load cycle
        do_reset();
        start();
        run_window(8'b0000_0001, 8'h00);
        run_window(8'b0100_0001, 8'b1000_0000);
        chk("ld_hs_valid", 32'(rpt_valid), 1);
        chk("ld_hs_count", 32'(rpt_count), 2);
        chk("ld_hs_alarm", 32'(rpt_alarm), 1);
        chk("ld_hs_ovr",   32'(overrun),   0);

        // Partial window discarded when en drops at cycle 5
        do_reset();
        start();
        for (int i = 0; i < 5; i++) begin
            y_in = (i < 3);
            tick();
        end
        en   = 1'b0;
        y_in = 1'b0;
        tick();
        chk("part_valid0", 32'(rpt_valid), 0);
        y_in = 1'b1;
        tick(); tick(); tick();
        chk("part_valid1", 32'(rpt_valid), 0);
        chk_total("part_total0", 3);
        start();
        run_window(8'b0000_1000, 8'h00);
        chk("part_valid2", 32'(rpt_valid), 1);
        chk("part_count",  32'(rpt_count), 1);
        chk("part_alarm",  32'(rpt_alarm), 0);
        chk("part_ovr",    32'(overrun),   0);
        chk_total("part_total1", 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
